// File: rtl/block_pkg.sv
// Shared constants, FSM state type and the ball/block overlap test for the
// falling-block spawner.
package block_pkg;

  localparam int          NUM_BLOCKS = 5;
  localparam int          SCREEN_H   = 480;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_e;

  // One axis: ball span [bp-bs, bp+bs] against block span [p, p+s].
  // Rearranged so that no term is ever subtracted.
  function automatic logic axis_hit(input logic [9:0] p, s, bp, bs);
    logic [10:0] ball_hi;
    logic [10:0] blk_hi;
    ball_hi = {1'b0, bp} + {1'b0, bs};
    blk_hi  = {1'b0, p} + {1'b0, s} + {1'b0, bs};
    return (ball_hi >= {1'b0, p}) && ({1'b0, bp} <= blk_hi);
  endfunction

  function automatic logic collide(input logic [9:0] x, y, s, bx, by, bs);
    return axis_hit(x, s, bx, bs) && axis_hit(y, s, by, bs);
  endfunction

endpackage

// File: rtl/block_spawner_lfsr16.sv
// 16-bit Galois LFSR (right shift) that steps only when asked to.
module lfsr16
  import block_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        advance,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     lfsr_q <= SEED;
    else if (advance) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign q = lfsr_q;

endmodule

// File: rtl/block_spawner.sv
// Per-frame falling-block state: moves, retires, clears on ball hits and
// spawns blocks in a short burst after each synchronised vsync edge.
module block_spawner
  import block_pkg::*;
#(
  parameter int          SPAWN_INTERVAL = 60,
  parameter int          FALL_STEP      = 1,
  parameter int          X_OFFSET       = 32,
  parameter int          MIN_SIZE       = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] BallX       [0:1],
  input  logic [9:0] BallY       [0:1],
  input  logic [9:0] Ball_size   [0:1],
  output logic [9:0] BlockX      [0:NUM_BLOCKS-1],
  output logic [9:0] BlockY      [0:NUM_BLOCKS-1],
  output logic [9:0] Block_size  [0:NUM_BLOCKS-1],
  output logic       block_ready [0:NUM_BLOCKS-1],
  output logic [7:0] hit_count,
  output logic       hit_pulse
);

  localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL + 1) : 1;

  // [0],[1] synchroniser, [2] previous value for edge detection
  logic [2:0]       fsync_q;
  logic             frame_tick;
  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       bx_q  [0:NUM_BLOCKS-1];
  logic [9:0]       bx_d  [0:NUM_BLOCKS-1];
  logic [9:0]       by_q  [0:NUM_BLOCKS-1];
  logic [9:0]       by_d  [0:NUM_BLOCKS-1];
  logic [9:0]       bs_q  [0:NUM_BLOCKS-1];
  logic [9:0]       bs_d  [0:NUM_BLOCKS-1];
  logic             rdy_q [0:NUM_BLOCKS-1];
  logic             rdy_d [0:NUM_BLOCKS-1];
  logic [7:0]       hc_q, hc_d;
  logic             hp_q, hp_d;
  logic [15:0]      lfsr;
  logic             lfsr_adv;
  logic [10:0]      ny;
  logic             hit;
  logic             free_found;
  logic [2:0]       free_idx;
  logic             unused_lfsr_hi;

  assign frame_tick     = fsync_q[1] & ~fsync_q[2];
  assign unused_lfsr_hi = ^lfsr[15:13];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .advance (lfsr_adv),
    .q       (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bx_d       = bx_q;
    by_d       = by_q;
    bs_d       = bs_q;
    rdy_d      = rdy_q;
    hc_d       = hc_q;
    hp_d       = 1'b0;
    lfsr_adv   = 1'b0;
    ny         = '0;
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (rdy_q[idx_q]) begin
          ny = {1'b0, by_q[idx_q]} + 11'(FALL_STEP);
          for (int b = 0; b < 2; b++)
            hit = hit | collide(bx_q[idx_q], ny[9:0], bs_q[idx_q],
                                BallX[b], BallY[b], Ball_size[b]);
          // Retire wins over hit: a block leaving the screen never scores.
          if (ny >= 11'(SCREEN_H)) begin
            rdy_d[idx_q] = 1'b0;
            by_d[idx_q]  = '0;
          end else begin
            by_d[idx_q] = ny[9:0];
            if (hit) begin
              rdy_d[idx_q] = 1'b0;
              hp_d         = 1'b1;
              if (hc_q != 8'hFF) hc_d = hc_q + 8'd1;
            end
          end
        end
        if (idx_q == 3'(NUM_BLOCKS - 1)) state_d = SPAWN;
        else                             idx_d   = idx_q + 3'd1;
      end
      SPAWN: begin
        state_d = IDLE;
        if (cnt_q == CNT_W'(SPAWN_INTERVAL - 1)) begin
          cnt_d = '0;
          // Descending scan so the lowest free index is the one kept.
          for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (!rdy_q[i]) begin
              free_found = 1'b1;
              free_idx   = 3'(i);
            end
          end
          if (free_found) begin
            bx_d[free_idx]  = 10'(X_OFFSET) + {1'b0, lfsr[8:0]};
            by_d[free_idx]  = '0;
            bs_d[free_idx]  = 10'(MIN_SIZE) + {6'b0, lfsr[12:9]};
            rdy_d[free_idx] = 1'b1;
            lfsr_adv        = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync_q <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bx_q    <= '{default: '0};
      by_q    <= '{default: '0};
      bs_q    <= '{default: '0};
      rdy_q   <= '{default: 1'b0};
      hc_q    <= '0;
      hp_q    <= 1'b0;
    end else begin
      fsync_q <= {fsync_q[1:0], frame_clk};
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bs_q    <= bs_d;
      rdy_q   <= rdy_d;
      hc_q    <= hc_d;
      hp_q    <= hp_d;
    end
  end

  assign BlockX      = bx_q;
  assign BlockY      = by_q;
  assign Block_size  = bs_q;
  assign block_ready = rdy_q;
  assign hit_count   = hc_q;
  assign hit_pulse   = hp_q;

endmodule

// File: tb/tb_block_spawner.sv
// Scoreboard bench for block_spawner: a frame-level reference model queues
// the expected geometry per frame; a monitor compares after each burst.
module tb_block_spawner;

  localparam int          NB    = 5;
  localparam int          SH    = 480;
  localparam int          INTV  = 1;
  localparam int          FALL  = 1;
  localparam int          XOFF  = 32;
  localparam int          MINS  = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic [9:0] BallX [0:1];
  logic [9:0] BallY [0:1];
  logic [9:0] Ball_size [0:1];
  logic [9:0] BlockX [0:NB-1];
  logic [9:0] BlockY [0:NB-1];
  logic [9:0] Block_size [0:NB-1];
  logic       block_ready [0:NB-1];
  logic [7:0] hit_count;
  logic       hit_pulse;

  block_spawner #(
    .SPAWN_INTERVAL (INTV),
    .FALL_STEP      (FALL),
    .X_OFFSET       (XOFF),
    .MIN_SIZE       (MINS),
    .LFSR_SEED      (SEED)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .BallX       (BallX),
    .BallY       (BallY),
    .Ball_size   (Ball_size),
    .BlockX      (BlockX),
    .BlockY      (BlockY),
    .Block_size  (Block_size),
    .block_ready (block_ready),
    .hit_count   (hit_count),
    .hit_pulse   (hit_pulse)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0][9:0] x;
    logic [4:0][9:0] y;
    logic [4:0][9:0] s;
    logic [4:0]      r;
    logic [7:0]      hc;
    logic [7:0]      hits;
  } snap_t;

  snap_t exp_q [$];
  int vecs = 0;
  int errs = 0;

  // Reference model state: a list of slots and a few counters.
  int          mx [NB];
  int          my [NB];
  int          ms [NB];
  bit          mr [NB];
  int          mhc;
  int          mcnt;
  logic [15:0] mlfsr;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] t;
    t = v >> 1;
    if (v[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic bit ovl(input int x, y, s, bx, by, bs);
    return (bx - bs <= x + s) && (bx + bs >= x) && (by - bs <= y + s) && (by + bs >= y);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i] = 0; my[i] = 0; ms[i] = 0; mr[i] = 0;
    end
    mhc = 0; mcnt = 0; mlfsr = SEED;
  endtask

  task automatic model_frame(output int hits);
    int ny;
    int f;
    hits = 0;
    for (int i = 0; i < NB; i++) begin
      if (mr[i]) begin
        ny = my[i] + FALL;
        if (ny >= SH) begin
          mr[i] = 0; my[i] = 0;
        end else begin
          my[i] = ny;
          if (ovl(mx[i], my[i], ms[i], int'(BallX[0]), int'(BallY[0]), int'(Ball_size[0])) ||
              ovl(mx[i], my[i], ms[i], int'(BallX[1]), int'(BallY[1]), int'(Ball_size[1]))) begin
            mr[i] = 0;
            hits++;
            if (mhc < 255) mhc++;
          end
        end
      end
    end
    if (mcnt == INTV - 1) begin
      mcnt = 0;
      f = -1;
      for (int i = 0; i < NB; i++) if (!mr[i] && f < 0) f = i;
      if (f >= 0) begin
        mx[f] = XOFF + int'(mlfsr[8:0]);
        my[f] = 0;
        ms[f] = MINS + int'(mlfsr[12:9]);
        mr[f] = 1;
        mlfsr = lfsr_step(mlfsr);
      end
    end else begin
      mcnt++;
    end
  endtask

  function automatic snap_t model_snap(input int hits);
    snap_t e;
    for (int i = 0; i < NB; i++) begin
      e.x[i] = 10'(mx[i]); e.y[i] = 10'(my[i]); e.s[i] = 10'(ms[i]); e.r[i] = mr[i];
    end
    e.hc   = 8'(mhc);
    e.hits = 8'(hits);
    return e;
  endfunction

  task automatic set_balls(input int x0, y0, s0, x1, y1, s1);
    BallX[0] = 10'(x0); BallY[0] = 10'(y0); Ball_size[0] = 10'(s0);
    BallX[1] = 10'(x1); BallY[1] = 10'(y1); Ball_size[1] = 10'(s1);
  endtask

  task automatic aim_at(input int k);
    set_balls(mx[k] + ms[k] / 2, my[k] + FALL, 1, 0, 0, 0);
  endtask

  task automatic do_frame(input bit dbl);
    int h;
    model_frame(h);
    exp_q.push_back(model_snap(h));
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    if (dbl) begin
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) frame_clk = 1'b0;
    end
    repeat (16) @(negedge Clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < NB; i++) begin
      chk({tag, "_X"}, i, 32'(BlockX[i]), 0);
      chk({tag, "_Y"}, i, 32'(BlockY[i]), 0);
      chk({tag, "_S"}, i, 32'(Block_size[i]), 0);
      chk({tag, "_rdy"}, i, 32'(block_ready[i]), 0);
    end
    chk({tag, "_hit_count"}, 0, 32'(hit_count), 0);
    chk({tag, "_hit_pulse"}, 0, 32'(hit_pulse), 0);
  endtask

  // Monitor: after each observed frame edge, count pulses through the burst
  // window and then compare the settled outputs with the next expectation.
  initial begin
    snap_t e;
    int    np;
    forever begin
      @(posedge frame_clk);
      np = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge Clk);
        if (hit_pulse === 1'b1) np++;
      end
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL scoreboard: burst seen with no expectation queued (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < NB; i++) begin
          chk("BlockX", i, 32'(BlockX[i]), 32'(e.x[i]));
          chk("BlockY", i, 32'(BlockY[i]), 32'(e.y[i]));
          chk("Block_size", i, 32'(Block_size[i]), 32'(e.s[i]));
          chk("block_ready", i, 32'(block_ready[i]), 32'(e.r[i]));
        end
        chk("hit_count", 0, 32'(hit_count), 32'(e.hc));
        chk("hit_pulses", 0, 32'(np), 32'(e.hits));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    set_balls(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge Clk);
    chk_zero("reset");
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Known spawn values from the seed, balls parked.
    do_frame(0);
    chk("spawn1_X", 0, 32'(BlockX[0]), 257);
    chk("spawn1_S", 0, 32'(Block_size[0]), 10);
    chk("spawn1_rdy", 0, 32'(block_ready[0]), 1);
    do_frame(0);
    chk("spawn2_Y0", 0, 32'(BlockY[0]), 1);
    chk("spawn2_X", 1, 32'(BlockX[1]), 144);
    chk("spawn2_Y", 1, 32'(BlockY[1]), 0);
    chk("spawn2_S", 1, 32'(Block_size[1]), 5);

    // Fill all slots, then one frame with a dropped spawn.
    repeat (4) do_frame(0);
    for (int i = 0; i < NB; i++) chk("full_rdy", i, 32'(block_ready[i]), 1);
    // Free slot 2 by a hit; the refill uses the unadvanced LFSR.
    aim_at(2);
    do_frame(0);
    chk("refill_rdy", 2, 32'(block_ready[2]), 1);
    chk("refill_Y", 2, 32'(BlockY[2]), 0);

    // Random balls.
    for (int n = 0; n < 40; n++) begin
      set_balls($urandom_range(600), $urandom_range(60), $urandom_range(40),
                $urandom_range(600), $urandom_range(60), $urandom_range(40));
      do_frame(0);
    end

    // Two vsync rises in quick succession give a single burst.
    set_balls(0, 0, 0, 0, 0, 0);
    do_frame(1);

    // Reset in the middle of an update burst.
    model_reset();
    exp_q.push_back(model_snap(0));
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk_zero("midreset");
    Reset_n = 1'b1;
    repeat (14) @(negedge Clk);

    // Hit slot 0 every frame until the counter saturates.
    do_frame(0);
    for (int n = 0; n < 258; n++) begin
      aim_at(0);
      do_frame(0);
    end
    chk("sat_hit_count", 0, 32'(hit_count), 255);

    // Parked balls long enough for blocks to fall off the bottom.
    set_balls(0, 0, 0, 0, 0, 0);
    repeat (485) do_frame(0);

    repeat (20) @(negedge Clk);
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/block_spawner.md
# block_spawner

Gameplay-state stage that sits directly upstream of the colour mapper and produces the falling-block geometry it renders: `BlockX`, `BlockY`, `Block_size` and `block_ready`, for five slots. Once per video frame it moves every live block down, retires blocks that have left the screen, clears blocks hit by either ball, and spawns new blocks at pseudo-random positions. The block is driven by the system clock and a frame strobe (VGA vsync). Its outputs change only during the short update burst after each frame edge.

## Interface
- `NUM_BLOCKS`, 5: number of block slots. The colour mapper is fixed at 5.
- `SCREEN_H`, 480: visible lines.
- `SPAWN_INTERVAL`, 60: frames between spawn attempts (≥1).
- `FALL_STEP`, 1: pixels moved down per frame.
- `X_OFFSET`, 32: left margin added to the random X.
- `MIN_SIZE`, 4: smallest block size.
- `LFSR_SEED`, 16'hACE1: nonzero seed.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vsync from the VGA controller; asynchronous to `Clk`.
- `BallX [0:1]`, `BallY [0:1]`, `Ball_size [0:1]` in 10 each: ball centres and half-sizes.
- `BlockX [0:4]`, `BlockY [0:4]`, `Block_size [0:4]` out 10 each: block top-left corner and extent. A block spans X..X+size and Y..Y+size.
- `block_ready [0:4]` out 1 each: slot is live.
- `hit_count` out 8: number of blocks destroyed, saturating at 255.
- `hit_pulse` out 1: one-cycle strobe for each destroyed block.

## Operation
- **Frame edge:** `frame_clk` passes through a 2-flop synchroniser, then a rising-edge detector, producing `frame_tick`.
- **FSM states:**
  - IDLE → UPDATE on `frame_tick`.
  - UPDATE steps slot index i from 0 to NUM_BLOCKS−1, one slot per cycle.
  - UPDATE → SPAWN after the last slot.
  - SPAWN → IDLE after one cycle.
- **UPDATE, live slot i:**
  - Compute `ny = BlockY[i] + FALL_STEP`.
  - If `ny ≥ SCREEN_H`: clear ready and set Y to 0 (retire).
  - Otherwise: set Y to `ny`, then test collision against both balls using `ny`.
  - On a hit: clear ready, pulse `hit_pulse`, increment `hit_count`.
  - Retire takes priority over hit, so a block leaving the screen never scores.
- **UPDATE, dead slot:** no change.
- **Collision test:** axis-aligned overlap using 11-bit unsigned arithmetic with no subtraction. For block (X, Y, S) and ball (BX, BY, BS):
  - X overlap: `BX + BS ≥ X` and `BX ≤ X + S + BS`.
  - Y overlap: the same with Y/BY.
  - Hit = X overlap and Y overlap, for either ball.
- **Spawn counter:** increments in SPAWN.
- **Spawn attempt:** when the counter equals `SPAWN_INTERVAL−1`, the counter returns to 0 and the lowest-index dead slot is loaded:
  - X = `X_OFFSET + lfsr[8:0]`
  - Y = 0
  - size = `MIN_SIZE + lfsr[12:9]`
  - ready = 1
- After a successful spawn the LFSR advances one step: Galois right-shift, taps 16'hB400. If all slots are live, the spawn is dropped and the LFSR does not advance.
- Dead slots hold their last X and size.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, counters 0, LFSR = `LFSR_SEED`. Reset may arrive mid-burst; all state is cleared immediately, with no partial update surviving.
- **Latency:** `frame_tick` occurs 3 Clk cycles after the `frame_clk` rise. The UPDATE burst takes NUM_BLOCKS cycles and SPAWN takes 1 cycle. All outputs are stable within 9 cycles of the edge.
- **Output registers:** every output is registered and changes only in UPDATE or SPAWN.
- **`hit_pulse`:** high for exactly 1 cycle per hit. Two hits in one frame produce two separate pulses.
- **`hit_count`:** saturates at 255; no wrap-around.
- **Early tick:** a `frame_tick` arriving while not in IDLE is ignored.
- **Ball inputs:** sampled at the cycle their slot is evaluated. The caller holds them stable during vblank.

## Structure
- **Package `block_pkg`:**
  - `NUM_BLOCKS`
  - `SCREEN_H`
  - state enum `{IDLE, UPDATE, SPAWN}`
  - LFSR tap constant 16'hB400
  - the collision function (11-bit overlap test)
- **Sub-module `lfsr16`:** inputs `Clk`, `Reset_n`, `advance`; parameter `SEED`; output `q[15:0]`.

## Test plan
- **Reset:** assert `Reset_n`=0 mid-UPDATE → all outputs 0 and FSM IDLE within 1 cycle; release, then 10 frames with `SPAWN_INTERVAL`=60 → no slot live.
- **Spawn values:** `SPAWN_INTERVAL`=1, balls parked at (0,0) size 0.
  - First frame → slot 0: X=257, Y=0, size=10, ready=1.
  - Second frame → slot 0 Y=1; slot 1: X=144, Y=0, size=5.
- **Retire:** slot with Y=479, `FALL_STEP`=1, one frame → ready=0, Y=0, `hit_count` unchanged, no `hit_pulse`.
- **Collision:** slot 0 at X=257, Y=0, size=10; ball 1 at (262,5) size 4; one frame → slot 0 ready=0, one `hit_pulse`, `hit_count`=1. A ball at (300,5) → no hit.
- **Full:** all 5 slots live, spawn due → nothing spawned, LFSR unchanged. Free slot 2 → the next spawn lands in slot 2 using the unchanged LFSR value.
- **Edge cases:**
  - `frame_clk` toggled twice within 4 cycles → exactly one update burst.
  - `hit_count` at 255 plus another hit → stays 255, `hit_pulse` still asserted.
